// File: rtl/final_pkg.sv
// Shared constants and state encoding for the FINAL host loader.
// Imported by the loader top and its timer.
package final_pkg;

  localparam int FINAL_ADDR_W   = 6;
  localparam int FINAL_DATA_W   = 32;
  localparam int FINAL_RESULT_W = 20;
  localparam int FINAL_MAX_WORDS = 64;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    GO,
    WAIT
  } final_host_state_t;

endpackage

// File: rtl/final_host_timer.sv
// Loadable up-counter with clear and terminal-count flag.
// Guards the WAIT state against a core that never finishes.
module final_host_timer #(
  parameter int W  = 12,
  parameter int TC = 4095
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);

  // Clear has priority over load, load over count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  assign tc = (count == W'(TC));

endmodule

// File: rtl/final_host_loader.sv
// Host-side loader: streams words into SRAM port B, then
// starts the core and captures its result or times out.
module final_host_loader
  import final_pkg::*;
#(
  parameter int ADDR_W      = FINAL_ADDR_W,
  parameter int DATA_W      = FINAL_DATA_W,
  parameter int RESULT_W    = FINAL_RESULT_W,
  parameter int MAX_WORDS   = FINAL_MAX_WORDS,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                Start,
  input  logic [ADDR_W:0]     Num_Words,
  input  logic [DATA_W-1:0]   In_Data,
  input  logic                In_Valid,
  output logic                In_Ready,
  output logic [DATA_W-1:0]   M_di32,
  output logic [ADDR_W-1:0]   M_Addr6,
  output logic                M_enb,
  output logic                M_web,
  output logic                Go_t,
  input  logic                Done_t,
  input  logic [RESULT_W-1:0] Result_t,
  output logic [RESULT_W-1:0] Result,
  output logic                Result_Valid,
  output logic                Busy,
  output logic                Timeout
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] MAXC = CNT_W'(MAX_WORDS);

  final_host_state_t state;
  logic [CNT_W-1:0]  rem;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  req;
  logic [TMR_W-1:0]  tmr_count;
  logic              tmr_tc;

  assign req      = (Num_Words > MAXC) ? MAXC : Num_Words;
  assign In_Ready = (state == LOAD);

  final_host_timer #(
    .W  (TMR_W),
    .TC (TIMEOUT_CYC - 1)
  ) u_timer (
    .clk      (Clk),
    .rst_n    (Rst_n),
    .clr      (state == GO),
    .load     (1'b0),
    .load_val ('0),
    .en       (state == WAIT),
    .count    (tmr_count),
    .tc       (tmr_tc)
  );

  // Sequencer: state, word counter and all registered outputs.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state        <= IDLE;
      rem          <= '0;
      addr         <= '0;
      M_di32       <= '0;
      M_Addr6      <= '0;
      M_enb        <= 1'b0;
      M_web        <= 1'b0;
      Go_t         <= 1'b0;
      Result       <= '0;
      Result_Valid <= 1'b0;
      Busy         <= 1'b0;
      Timeout      <= 1'b0;
    end else begin
      M_enb        <= 1'b0;
      M_web        <= 1'b0;
      Result_Valid <= 1'b0;
      Timeout      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (Start) begin
            rem   <= req;
            addr  <= '0;
            Busy  <= 1'b1;
            state <= (req != '0) ? LOAD : GO;
          end
        end
        LOAD: begin
          if (In_Valid) begin
            M_enb   <= 1'b1;
            M_web   <= 1'b1;
            M_Addr6 <= addr;
            M_di32  <= In_Data;
            addr    <= addr + ADDR_W'(1);
            rem     <= rem - CNT_W'(1);
            if (rem == CNT_W'(1)) state <= FLUSH;
          end
        end
        FLUSH: state <= GO;
        GO: begin
          Go_t  <= 1'b1;
          state <= WAIT;
        end
        WAIT: begin
          if (Done_t) begin
            Result       <= Result_t;
            Result_Valid <= 1'b1;
            Go_t         <= 1'b0;
            Busy         <= 1'b0;
            state        <= IDLE;
          end else if (tmr_tc) begin
            Timeout <= 1'b1;
            Go_t    <= 1'b0;
            Busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_final_host_loader.sv
// Directed testbench for final_host_loader.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_final_host_loader;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Start = 1'b0;
  logic [6:0]  Num_Words = '0;
  logic [31:0] In_Data = '0;
  logic        In_Valid = 1'b0;
  logic        In_Ready;
  logic [31:0] M_di32;
  logic [5:0]  M_Addr6;
  logic        M_enb;
  logic        M_web;
  logic        Go_t;
  logic        Done_t = 1'b0;
  logic [19:0] Result_t = '0;
  logic [19:0] Result;
  logic        Result_Valid;
  logic        Busy;
  logic        Timeout;

  int tests = 0;
  int fails = 0;

  final_host_loader dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .Start        (Start),
    .Num_Words    (Num_Words),
    .In_Data      (In_Data),
    .In_Valid     (In_Valid),
    .In_Ready     (In_Ready),
    .M_di32       (M_di32),
    .M_Addr6      (M_Addr6),
    .M_enb        (M_enb),
    .M_web        (M_web),
    .Go_t         (Go_t),
    .Done_t       (Done_t),
    .Result_t     (Result_t),
    .Result       (Result),
    .Result_Valid (Result_Valid),
    .Busy         (Busy),
    .Timeout      (Timeout)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int exp_addr;
    logic seen;
    logic go_ok;
    logic [5:0] pat;

    // Reset state
    tick();
    check("rst_busy", Busy, 0);
    check("rst_go", Go_t, 0);
    check("rst_enb", M_enb, 0);
    check("rst_web", M_web, 0);
    check("rst_rdy", In_Ready, 0);
    check("rst_res", Result, 0);
    check("rst_tmo", Timeout, 0);
    Rst_n = 1'b1;
    tick();

    // Scenario 1: four words, Done_t with 0x12345
    Start = 1; Num_Words = 4;
    tick();
    Start = 0;
    check("s1_busy", Busy, 1);
    check("s1_rdy", In_Ready, 1);
    check("s1_enb0", M_enb, 0);
    for (int i = 0; i < 4; i++) begin
      In_Valid = 1; In_Data = 32'hA0 + i;
      tick();
      check("s1_enb", M_enb, 1);
      check("s1_web", M_web, 1);
      check("s1_addr", M_Addr6, i);
      check("s1_data", M_di32, 32'hA0 + i);
    end
    In_Valid = 0;
    check("s1_flush_rdy", In_Ready, 0);
    check("s1_go_h1", Go_t, 0);
    tick();
    check("s1_go_h2", Go_t, 0);
    check("s1_enb_go", M_enb, 0);
    tick();
    check("s1_go_h3", Go_t, 1);
    Done_t = 1; Result_t = 20'h12345;
    tick();
    Done_t = 0;
    check("s1_res", Result, 20'h12345);
    check("s1_rv", Result_Valid, 1);
    check("s1_go_off", Go_t, 0);
    check("s1_busy_off", Busy, 0);
    tick();
    check("s1_rv_once", Result_Valid, 0);
    check("s1_res_hold", Result, 20'h12345);

    // Scenario 2: Num_Words=100 clamps to 64
    Start = 1; Num_Words = 100;
    tick();
    Start = 0;
    for (int i = 0; i < 64; i++) begin
      In_Valid = 1; In_Data = 32'h100 + i;
      tick();
      check("s2_enb", M_enb, 1);
      check("s2_addr", M_Addr6, i);
      check("s2_data", M_di32, 32'h100 + i);
    end
    check("s2_rdy_end", In_Ready, 0);
    In_Data = 32'hDEAD;
    tick();
    check("s2_no_wrap_a", M_enb, 0);
    tick();
    check("s2_no_wrap_b", M_enb, 0);
    check("s2_go", Go_t, 1);
    In_Valid = 0;
    Done_t = 1; Result_t = 20'h00ABC;
    tick();
    Done_t = 0;
    check("s2_res", Result, 20'h00ABC);

    // Scenario 3: In_Valid gaps 1,0,0,1,0,1
    Start = 1; Num_Words = 3;
    tick();
    Start = 0;
    pat = 6'b101001;
    exp_addr = 0;
    for (int i = 0; i < 6; i++) begin
      In_Valid = pat[i]; In_Data = 32'hB0 + i;
      tick();
      check("s3_enb", M_enb, pat[i]);
      if (pat[i]) begin
        check("s3_addr", M_Addr6, exp_addr);
        check("s3_data", M_di32, 32'hB0 + i);
        exp_addr++;
      end
    end
    In_Valid = 0;
    check("s3_rdy_end", In_Ready, 0);
    tick();
    tick();
    check("s3_go", Go_t, 1);
    Done_t = 1; Result_t = 20'h54321;
    tick();
    Done_t = 0;
    check("s3_res", Result, 20'h54321);

    // Scenario 4: zero words, no Done_t, timeout
    Start = 1; Num_Words = 0;
    tick();
    Start = 0;
    check("s4_busy", Busy, 1);
    check("s4_rdy", In_Ready, 0);
    check("s4_go1", Go_t, 0);
    tick();
    check("s4_go2", Go_t, 1);
    n = 0; seen = 0; go_ok = 1;
    while (!seen && n < 5000) begin
      tick();
      n++;
      if (M_enb) go_ok = 0;
      if (Timeout) seen = 1;
      else if (!Go_t) go_ok = 0;
    end
    check("s4_tmo_seen", seen, 1);
    check("s4_tmo_cycles", n, 4096);
    check("s4_go_held", go_ok, 1);
    check("s4_go_off", Go_t, 0);
    check("s4_busy_off", Busy, 0);
    check("s4_res_kept", Result, 20'h54321);
    check("s4_rv", Result_Valid, 0);
    tick();
    check("s4_tmo_pulse", Timeout, 0);

    // Scenario 5: reset during the second write
    Start = 1; Num_Words = 4;
    tick();
    Start = 0;
    In_Valid = 1; In_Data = 32'hC0;
    tick();
    In_Data = 32'hC1;
    tick();
    check("s5_wr2", M_enb, 1);
    #2 Rst_n = 0;
    #1;
    check("s5_enb", M_enb, 0);
    check("s5_web", M_web, 0);
    check("s5_go", Go_t, 0);
    check("s5_busy", Busy, 0);
    tick();
    Rst_n = 1; In_Valid = 0;
    tick();
    check("s5_idle_busy", Busy, 0);
    check("s5_idle_rdy", In_Ready, 0);

    // Scenario 6: Done_t during LOAD, Start during WAIT
    Start = 1; Num_Words = 4; Done_t = 1; Result_t = 20'h11111;
    tick();
    Start = 0;
    check("s6_rdy", In_Ready, 1);
    for (int i = 0; i < 4; i++) begin
      In_Valid = 1; In_Data = 32'hD0 + i;
      tick();
      check("s6_addr", M_Addr6, i);
      check("s6_busy", Busy, 1);
    end
    In_Valid = 0;
    tick();
    check("s6_go_h2", Go_t, 0);
    Done_t = 0;
    tick();
    check("s6_go_h3", Go_t, 1);
    check("s6_res_old", Result, 0);
    Start = 1; Num_Words = 2;
    tick();
    Start = 0;
    check("s6_start_ign", Busy, 1);
    check("s6_go_wait", Go_t, 1);
    check("s6_rdy_wait", In_Ready, 0);
    Done_t = 1; Result_t = 20'h0F0F0;
    tick();
    Done_t = 0;
    check("s6_res", Result, 20'h0F0F0);
    check("s6_rv", Result_Valid, 1);
    check("s6_busy_off", Busy, 0);
    tick();
    check("s6_no_queued", Busy, 0);
    check("s6_rdy_idle", In_Ready, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/final_host_loader.md
Name: final_host_loader

Overview:
- Host-side driver for the FINAL core subsystem: the writer and initiator opposite the core's port-A reader and its Go/Done responder.
- Accepts a stream of 32-bit words over a valid/ready handshake and writes them into dual-port SRAM port B (M_di32, M_Addr6, M_enb, M_web).
- Then raises Go_t, waits for Done_t, and captures the 20-bit Result_t for the host.
- A timeout guards against a core that never finishes.

Parameters:
- ADDR_W, 6, port-B word address width.
- DATA_W, 32, port-B data width.
- RESULT_W, 20, core result width.
- MAX_WORDS, 64, port-B depth (2**ADDR_W).
- TIMEOUT_CYC, 4096, maximum cycles in WAIT before abort.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- Start  in  1  one-cycle request to begin a load/run sequence.
- Num_Words  in  7  word count sampled with Start; 0 = run without load; values above 64 clamp to 64.
- In_Data  in  32  stream word.
- In_Valid  in  1  stream word valid.
- In_Ready  out  1  loader accepts a word this cycle.
- M_di32  out  32  SRAM port-B write data.
- M_Addr6  out  6  SRAM port-B address.
- M_enb  out  1  SRAM port-B enable.
- M_web  out  1  SRAM port-B write enable.
- Go_t  out  1  core start, level.
- Done_t  in  1  core completion.
- Result_t  in  20  core result.
- Result  out  20  captured result, held until the next capture.
- Result_Valid  out  1  one-cycle pulse when Result updates.
- Busy  out  1  high in any state other than IDLE.
- Timeout  out  1  one-cycle pulse on abort.

Behaviour:
- Reset (asynchronous, Rst_n=0): state IDLE; all outputs 0, including Result; word counter and timer cleared. Reset in mid-operation deasserts M_enb/M_web immediately, so no partial write occurs. SRAM contents are not cleared.
- All outputs are registered except In_Ready, which decodes directly from state.
- States: IDLE, LOAD, FLUSH, GO, WAIT.
- IDLE:
  - Start=1 latches clamp(Num_Words) into the remaining-count register and clears the address counter.
  - Next state is LOAD if the count is nonzero, else GO.
  - Start while Busy=1 is ignored.
- LOAD:
  - In_Ready=1.
  - Each In_Valid&&In_Ready handshake registers a write. On the following cycle: M_enb=1, M_web=1, M_Addr6=address counter, M_di32=word.
  - Address increments by 1 per accepted word and wraps 63→0 only after the 64th word, which is also the last.
  - Cycles without In_Valid produce M_enb=0, M_web=0.
  - On acceptance of the final word, go to FLUSH.
- FLUSH: single cycle in which the last write is presented on port B; In_Ready=0. Go to GO.
- GO: Go_t=1; timer cleared. Go to WAIT.
- WAIT:
  - Go_t stays 1; timer increments each cycle.
  - First cycle with Done_t=1: Result←Result_t, Result_Valid=1 on the next cycle, Go_t←0, go to IDLE.
  - If the timer reaches TIMEOUT_CYC-1 with Done_t=0: Timeout pulses, Go_t←0, Result unchanged, go to IDLE.
  - If Done_t and the timeout coincide on the same cycle, Done wins.
- Done_t is ignored in every state except WAIT.
- Latency:
  - Start to first In_Ready: 1 cycle.
  - Handshake to port-B write: 1 cycle.
  - Last handshake to Go_t rising: 3 cycles (via FLUSH and GO).
  - Done_t sampled high to Result_Valid: 1 cycle.
- Width rule: Num_Words>64 is saturated to 64 and never wraps the count.

Decomposition:
- Package final_pkg holds:
  - constants FINAL_ADDR_W=6, FINAL_DATA_W=32, FINAL_RESULT_W=20, FINAL_MAX_WORDS=64;
  - the state enum final_host_state_t {IDLE, LOAD, FLUSH, GO, WAIT}.
- One sub-module, final_host_timer: a loadable up-counter with clear and terminal-count flag, used for the WAIT timeout.
- The word/address counter stays inline.

Test Plan:
- Start with Num_Words=4, words 0xA0..0xA3 with In_Valid held high → writes to addresses 0..3 on consecutive cycles; Go_t rises 3 cycles after the 4th handshake. Core returns Done_t with Result_t=0x12345 → Result=0x12345, Result_Valid pulses once, Busy=0.
- Num_Words=100, 64 words streamed → exactly 64 writes at addresses 0..63; In_Ready=0 after the 64th; no write to address 0 afterwards.
- Num_Words=3 with In_Valid toggled 1,0,0,1,0,1 → three writes at addresses 0,1,2, each one cycle after its handshake; M_enb=0 on idle cycles.
- Num_Words=0 → no port-B activity; Go_t rises 2 cycles after Start. Done_t never asserts → Timeout pulses after 4096 WAIT cycles, Go_t=0, Result keeps its prior value.
- Rst_n pulled low during the second write of a 4-word load → M_enb/M_web/Go_t drop immediately; after release the block is IDLE with Busy=0; a fresh Start runs normally.
- Done_t=1 during LOAD, and Start pulsed during WAIT → both ignored; the sequence completes as in scenario 1.
